// File: rtl/noc_inject_arbiter_if.sv
// Requester-side bundle of the tile injection arbiter: per-requester flit
// handshake, downstream stall and the registered router-facing outputs.
interface noc_inject_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned FLIT_W  = 12
) ();
  localparam int unsigned IdW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*FLIT_W-1:0] req_flit;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      stall;
  logic [FLIT_W:0]           outdata_p;
  logic [IdW-1:0]            grant_id;
  logic                      busy;
  logic                      trunc_err;

  // Requesters and router side (testbench / surrounding tile logic).
  modport master (
    output req_valid, req_flit, req_last, stall,
    input  req_ready, outdata_p, grant_id, busy, trunc_err
  );

  // The arbiter itself.
  modport slave (
    input  req_valid, req_flit, req_last, stall,
    output req_ready, outdata_p, grant_id, busy, trunc_err
  );
endinterface

// File: rtl/noc_inject_arbiter.sv
// Packet-granular round-robin arbiter for a tile's local router injection port.
// A grant is locked from the first flit until the owner's last flit (or a forced
// release at MAX_PKT_LEN flits), so packets never interleave at the router.
module noc_inject_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned FLIT_W      = 12,
  parameter int unsigned MAX_PKT_LEN = 8
) (
  input logic                clk,
  input logic                rst,
  noc_inject_arbiter_if.slave bus
);
  localparam int unsigned IdW  = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(MAX_PKT_LEN) + 1;

  typedef enum logic [0:0] {StIdle, StPkt} state_e;

  state_e              state_q, state_d;
  logic [IdW-1:0]      rr_q, rr_d;
  logic [IdW-1:0]      grant_q, grant_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [FLIT_W:0]     out_q, out_d;
  logic                trunc_q, trunc_d;

  logic                cand_found;
  logic [IdW-1:0]      cand;
  logic [IdW-1:0]      sel;
  logic                go;
  logic                accept;
  logic [NUM_REQ-1:0]  ready;
  logic [FLIT_W-1:0]   acc_flit;
  logic                acc_last;
  logic [IdW-1:0]      sel_inc;

  // Round-robin search for the first valid requester at or above rr_q (wrapping).
  always_comb begin
    int unsigned idx;
    cand_found = 1'b0;
    cand       = '0;
    idx        = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rr_q) + k) % NUM_REQ;
      if (!cand_found && bus.req_valid[idx]) begin
        cand_found = 1'b1;
        cand       = IdW'(idx);
      end
    end
  end

  // Grant decode: the locked owner in PKT, the fresh candidate in IDLE.
  always_comb begin
    sel      = (state_q == StPkt) ? grant_q : cand;
    go       = !rst && !bus.stall && ((state_q == StPkt) || cand_found);
    ready    = '0;
    if (go) ready[sel] = 1'b1;
    accept   = go && bus.req_valid[sel];
    acc_flit = bus.req_flit[32'(sel)*FLIT_W +: FLIT_W];
    acc_last = bus.req_last[sel];
    sel_inc  = (sel == IdW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
  end

  // Next-state: packet lock, round-robin pointer, flit count and output flit.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    count_d = count_q;
    trunc_d = 1'b0;
    out_d   = '0;
    if (accept) begin
      out_d   = {1'b1, acc_flit};
      grant_d = sel;
      if (state_q == StIdle) begin
        count_d = CntW'(1);
        if (acc_last) rr_d = sel_inc;
        else          state_d = StPkt;
      end else begin
        count_d = count_q + 1'b1;
        if (acc_last) begin
          state_d = StIdle;
          rr_d    = sel_inc;
        end else if (count_q == CntW'(MAX_PKT_LEN - 1)) begin
          // Forced release: this flit still goes out, the packet is cut here.
          state_d = StIdle;
          rr_d    = sel_inc;
          trunc_d = 1'b1;
        end
      end
    end
  end

  // State registers with synchronous reset; reset drops any packet in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      rr_q    <= '0;
      grant_q <= '0;
      count_q <= '0;
      out_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      count_q <= count_d;
      out_q   <= out_d;
      trunc_q <= trunc_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.outdata_p = out_q;
  assign bus.grant_id  = grant_q;
  assign bus.busy      = (state_q == StPkt);
  assign bus.trunc_err = trunc_q;

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Directed table-driven bench for noc_inject_arbiter (NUM_REQ=4, FLIT_W=12,
// MAX_PKT_LEN=8). Each vector is one cycle: inputs driven after the rising
// edge, combinational ready and registered outputs sampled on the falling edge.
module tb_noc_inject_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;

  noc_inject_arbiter_if #(.NUM_REQ(4), .FLIT_W(12)) bus_if ();

  noc_inject_arbiter #(
    .NUM_REQ    (4),
    .FLIT_W     (12),
    .MAX_PKT_LEN(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic        stall;
    logic [47:0] flits;
    logic [3:0]  ready;
    logic [12:0] out;
    logic [1:0]  gid;
    logic        busy;
    logic        trunc;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [47:0] f(input int r, input logic [11:0] v);
    logic [47:0] w;
    w = '0;
    w[r*12 +: 12] = v;
    return w;
  endfunction

  task automatic add(input logic r, input logic [3:0] v, input logic [3:0] l, input logic s,
                     input logic [47:0] fl, input logic [3:0] rdy, input logic [12:0] o,
                     input logic [1:0] g, input logic b, input logic t);
    vec_t x;
    x.rst = r; x.valid = v; x.last = l; x.stall = s; x.flits = fl;
    x.ready = rdy; x.out = o; x.gid = g; x.busy = b; x.trunc = t;
    vecs.push_back(x);
  endtask

  task automatic check(input string what, input int vi, input logic [15:0] got,
                       input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL v%0d %s: got %h want %h", vi, what, got, want);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    int  nvalid;
    logic seen;

    // rst valid last stall flits | ready out gid busy trunc
    // Test 1: reset state, then a single-flit packet from req0.
    add(1, 4'b0001, 4'b0001, 0, f(0, 12'hA5C),  4'b0000, 13'h0000, 0, 0, 0); // v0
    add(0, 4'b0001, 4'b0001, 0, f(0, 12'hA5C),  4'b0001, 13'h0000, 0, 0, 0);
    add(0, 4'b0000, 4'b0000, 0, '0,             4'b0000, 13'h1A5C, 0, 0, 0);
    // Test 2: req0 and req2 both with 3-flit packets, from rr_ptr=0.
    add(1, 4'b0000, 4'b0000, 0, '0,             4'b0000, 13'h0000, 0, 0, 0);
    add(0, 4'b0101, 4'b0000, 0, f(0, 12'h101) | f(2, 12'h201), 4'b0001, 13'h0000, 0, 0, 0);
    add(0, 4'b0101, 4'b0000, 0, f(0, 12'h102) | f(2, 12'h201), 4'b0001, 13'h1101, 0, 1, 0);
    add(0, 4'b0101, 4'b0001, 0, f(0, 12'h103) | f(2, 12'h201), 4'b0001, 13'h1102, 0, 1, 0);
    add(0, 4'b0101, 4'b0000, 0, f(0, 12'h104) | f(2, 12'h201), 4'b0100, 13'h1103, 0, 0, 0);
    add(0, 4'b0101, 4'b0000, 0, f(0, 12'h104) | f(2, 12'h202), 4'b0100, 13'h1201, 2, 1, 0);
    add(0, 4'b0101, 4'b0100, 0, f(0, 12'h104) | f(2, 12'h203), 4'b0100, 13'h1202, 2, 1, 0);
    add(0, 4'b0000, 4'b0000, 0, '0,             4'b0000, 13'h1203, 2, 0, 0); // v10
    // Test 3: all four continuously valid with 1-flit packets.
    add(1, 4'b1111, 4'b1111, 0, '0,             4'b0000, 13'h0000, 2, 0, 0);
    for (int i = 0; i < 5; i++) begin
      add(0, 4'b1111, 4'b1111, 0,
          f(0, 12'h300) | f(1, 12'h301) | f(2, 12'h302) | f(3, 12'h303),
          4'(1 << (i % 4)), (i == 0) ? 13'h0000 : 13'(13'h1300 + (i - 1)),
          (i == 0) ? 2'd0 : 2'(i - 1), 0, 0);
    end
    add(0, 4'b0000, 4'b0000, 0, '0,             4'b0000, 13'h1300, 0, 0, 0);
    // Test 4: req1 streams without last; forced release after 8 flits.
    add(0, 4'b0010, 4'b0000, 0, f(1, 12'h401), 4'b0010, 13'h0000, 0, 0, 0);
    for (int i = 2; i <= 8; i++) begin
      add(0, 4'b0010, 4'b0000, 0, f(1, 12'(12'h400 + i)), 4'b0010,
          13'(13'h1400 + i - 1), 1, 1, 0);
    end
    add(0, 4'b0010, 4'b0000, 0, f(1, 12'h409), 4'b0010, 13'h1408, 1, 0, 1);
    add(0, 4'b0010, 4'b0000, 0, f(1, 12'h40A), 4'b0010, 13'h1409, 1, 1, 0);
    // Owner bubble keeps the lock; ready still offered to the owner.
    add(0, 4'b0000, 4'b0000, 0, '0,             4'b0010, 13'h140A, 1, 1, 0);
    add(0, 4'b0010, 4'b0010, 0, f(1, 12'h40B), 4'b0010, 13'h0000, 1, 1, 0);
    add(0, 4'b0000, 4'b0000, 0, '0,             4'b0000, 13'h140B, 1, 0, 0);
    // Test 5: 3-cycle stall in the middle of a 4-flit packet from req2.
    add(0, 4'b0100, 4'b0000, 0, f(2, 12'h501), 4'b0100, 13'h0000, 1, 0, 0);
    add(0, 4'b0100, 4'b0000, 0, f(2, 12'h502), 4'b0100, 13'h1501, 2, 1, 0);
    add(0, 4'b0100, 4'b0000, 1, f(2, 12'h503), 4'b0000, 13'h1502, 2, 1, 0);
    add(0, 4'b0100, 4'b0000, 1, f(2, 12'h503), 4'b0000, 13'h0000, 2, 1, 0);
    add(0, 4'b0100, 4'b0000, 1, f(2, 12'h503), 4'b0000, 13'h0000, 2, 1, 0);
    add(0, 4'b0100, 4'b0000, 0, f(2, 12'h503), 4'b0100, 13'h0000, 2, 1, 0);
    add(0, 4'b0100, 4'b0100, 0, f(2, 12'h504), 4'b0100, 13'h1503, 2, 1, 0);
    // Stall in IDLE blocks a fresh grant.
    add(0, 4'b0001, 4'b0001, 1, f(0, 12'h7FF), 4'b0000, 13'h1504, 2, 0, 0);
    // Test 6: reset after flit 2 of a req3 packet; req0 then wins from rr_ptr=0.
    add(0, 4'b1000, 4'b0000, 0, f(3, 12'h601), 4'b1000, 13'h0000, 2, 0, 0);
    add(0, 4'b1000, 4'b0000, 0, f(3, 12'h602), 4'b1000, 13'h1601, 3, 1, 0);
    add(1, 4'b1001, 4'b0000, 0, f(3, 12'h603) | f(0, 12'h6A0), 4'b0000, 13'h1602, 3, 1, 0);
    add(0, 4'b1001, 4'b0001, 0, f(3, 12'h601) | f(0, 12'h6A0), 4'b0001, 13'h0000, 0, 0, 0);
    add(0, 4'b1000, 4'b0000, 0, f(3, 12'h601), 4'b1000, 13'h16A0, 0, 0, 0);
    add(0, 4'b0000, 4'b0000, 0, '0,             4'b1000, 13'h1601, 3, 1, 0);

    bus_if.req_valid = '0;
    bus_if.req_last  = '0;
    bus_if.req_flit  = '0;
    bus_if.stall     = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      rst              = vecs[i].rst;
      bus_if.req_valid = vecs[i].valid;
      bus_if.req_last  = vecs[i].last;
      bus_if.stall     = vecs[i].stall;
      bus_if.req_flit  = vecs[i].flits;
      @(negedge clk);
      check("req_ready", i, 16'(bus_if.req_ready), 16'(vecs[i].ready));
      check("outdata_p", i, 16'(bus_if.outdata_p), 16'(vecs[i].out));
      check("grant_id",  i, 16'(bus_if.grant_id),  16'(vecs[i].gid));
      check("busy",      i, 16'(bus_if.busy),      16'(vecs[i].busy));
      check("trunc_err", i, 16'(bus_if.trunc_err), 16'(vecs[i].trunc));
    end

    // Hand sequence: req0 streams with no last; trunc_err must appear alongside
    // the 8th forwarded flit, and the re-grab must continue with no bubble.
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus_if.req_valid = '0;
    bus_if.req_last  = '0;
    bus_if.stall     = 1'b0;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    cyc    = 0;
    nvalid = 0;
    seen   = 1'b0;
    while (!seen && cyc < 20) begin
      if (cyc > 0) begin
        @(posedge clk);
        #1;
      end
      cyc++;
      bus_if.req_valid = 4'b0001;
      bus_if.req_flit  = f(0, 12'(cyc));
      @(negedge clk);
      if (bus_if.outdata_p[12]) nvalid++;
      if (bus_if.trunc_err) seen = 1'b1;
    end
    check("seq_trunc_seen",   100, 16'(seen),   16'd1);
    check("seq_flits_before", 100, 16'(nvalid), 16'd8);
    check("seq_trunc_cycle",  100, 16'(cyc),    16'd9);
    @(posedge clk);
    #1;
    bus_if.req_flit = f(0, 12'd10);
    @(negedge clk);
    check("seq_regrab_out",   101, 16'(bus_if.outdata_p), 16'h1009);
    check("seq_trunc_pulse",  101, 16'(bus_if.trunc_err), 16'd0);
    check("seq_regrab_busy",  101, 16'(bus_if.busy),      16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/noc_inject_arbiter.md
Name: noc_inject_arbiter

Overview:
Shares a tile's single local router injection port (13-bit flit: bit 12 = valid, bits 11:0 = payload) among several on-tile requesters, e.g. the CPU-to-router FIFO, a DMA engine and a debug/boot agent. Arbitration is round-robin at packet granularity. A grant is held until the requester's last flit, so packets from different requesters never interleave at the router. Output is registered and drives the router's local input directly.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..8.
FLIT_W, 12, payload width per flit, excluding the valid bit.
MAX_PKT_LEN, 8, maximum flits per packet before a forced release; legal range 2..255.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  NUM_REQ  per-requester flit valid
req_flit  input  NUM_REQ*FLIT_W  per-requester payload; requester i occupies bits [i*FLIT_W +: FLIT_W]
req_last  input  NUM_REQ  flit is the last of its packet
req_ready  output  NUM_REQ  per-requester accept; flit transfers when valid&ready
stall  input  1  downstream hold; while 1, no flit is accepted
outdata_p  output  FLIT_W+1  flit to router local port; bit FLIT_W = valid
grant_id  output  clog2(NUM_REQ)  index of the current or most recent owner
busy  output  1  a packet is locked (state PKT)
trunc_err  output  1  one-cycle pulse on a forced release

Behaviour:
- Reset (rst=1 at a clk edge) sets: state IDLE, rr_ptr=0, flit count=0, outdata_p=0, grant_id=0, busy=0, trunc_err=0. req_ready is combinational and is all-zero while rst=1.
- Reset mid-packet abandons the packet with no error pulse. The output flit is cleared on that same edge.
- State machine has two states, IDLE and PKT.
- IDLE:
  - Candidate = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - If stall=0 and a candidate exists, req_ready[candidate]=1 and all other ready bits are 0. The grant is combinational, so the first flit is accepted in the same cycle.
  - On acceptance, grant_id<=candidate and count<=1.
    - If req_last=1: stay in IDLE and set rr_ptr<=candidate+1 (mod NUM_REQ).
    - Otherwise: go to PKT and set busy<=1.
- PKT:
  - req_ready[grant_id]=!stall; all other ready bits are 0.
  - Each accepted flit increments count.
  - Accepted flit with req_last=1: go to IDLE, busy<=0, rr_ptr<=grant_id+1.
  - Accepted flit with req_last=0 when count==MAX_PKT_LEN-1: go to IDLE, busy<=0, rr_ptr<=grant_id+1, trunc_err<=1 for one cycle. The flit itself is still forwarded.
  - Owner deasserting req_valid mid-packet keeps the lock. Bubbles are allowed and no timeout applies.
- Output:
  - Each clk edge: outdata_p <= {1'b1, accepted payload} if a transfer occurred, else all zeros. Latency is exactly one cycle from acceptance.
  - With a continuous owner and stall=0, throughput is 1 flit/cycle.
  - IDLE re-arbitrates in the cycle right after a last flit, so back-to-back packets from different requesters have zero bubble.
- stall=1 forces every req_ready to 0, so outdata_p valid is 0 next cycle. State, count and ownership are held.
- Simultaneous requests in IDLE: the requester nearest rr_ptr (upward, with wrap) wins. Every continuously requesting source is served within NUM_REQ packets.
- Width rules:
  - count is clog2(MAX_PKT_LEN)+1 bits and never wraps; forced release occurs first.
  - rr_ptr increment wraps from NUM_REQ-1 to 0.
- req_flit and req_last are don't-care when the matching req_valid=0.

Test Plan:
1. Reset, then req_valid=4'b0001 with a single flit 12'hA5C, last=1 → req_ready=4'b0001 that cycle; outdata_p=13'h1A5C next cycle; busy stays 0; rr_ptr=1.
2. Req0 and req2 valid together, each sending a 3-flit packet (0x101..0x103 and 0x201..0x203) → outdata_p carries 0x101,0x102,0x103,0x201,0x202,0x203 on 6 consecutive cycles with no interleave; grant_id 0 then 2.
3. All four requesters hold valid continuously with 1-flit packets → grant order 0,1,2,3,0 and 1 flit/cycle.
4. Req1 sends 10 flits, none with last, MAX_PKT_LEN=8 → 8 flits forwarded; trunc_err pulses in the cycle after flit 8 is accepted; the next grant goes to another valid requester, or back to req1 if it is the only one.
5. stall=1 for 3 cycles in the middle of a 4-flit packet → req_ready=0 and outdata_p=0 for 3 cycles; busy=1 throughout; the remaining flits follow in order afterwards.
6. rst=1 after flit 2 of a 5-flit packet from req3 → next cycle outdata_p=0, busy=0, grant_id=0; after release, req0 (rr_ptr=0) wins over req3 if both are valid.
